// File: rtl/bitsieve_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : bitsieve_pkg
// Brief  : Shared BitSieve constants, FSM encoding and index type.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
package bitsieve_pkg;

  localparam int DEFAULT_N_SPINS = 1024;
  localparam int DEFAULT_IDX_W   = 10;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    ANNOUNCE = 1'b1
  } state_e;

  typedef logic [DEFAULT_IDX_W-1:0] spin_idx_t;

endpackage
`default_nettype wire

// File: rtl/bitsieve_flip_applier_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : bitsieve_flip_applier_if
// Brief  : Index-in / flip-out handshake bundle of the flip applier.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
interface bitsieve_flip_applier_if
  import bitsieve_pkg::*;
#(
  parameter int N_SPINS = DEFAULT_N_SPINS,
  parameter int IDX_W   = DEFAULT_IDX_W,
  parameter int CNT_W   = 32
);
  logic [IDX_W-1:0]   idx_i;
  logic               v_i;
  logic               ready_o;
  logic               load_i;
  logic [N_SPINS-1:0] spin_init_i;
  logic [N_SPINS-1:0] spin_o;
  logic               flip_v_o;
  logic [IDX_W-1:0]   flip_idx_o;
  logic               flip_ack_i;
  logic [CNT_W-1:0]   flip_cnt_o;
  logic               err_o;

  modport master (
    output idx_i, v_i, load_i, spin_init_i, flip_ack_i,
    input  ready_o, spin_o, flip_v_o, flip_idx_o, flip_cnt_o, err_o
  );

  modport slave (
    input  idx_i, v_i, load_i, spin_init_i, flip_ack_i,
    output ready_o, spin_o, flip_v_o, flip_idx_o, flip_cnt_o, err_o
  );
endinterface
`default_nettype wire

// File: rtl/bitsieve_index_decoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : bitsieve_index_decoder
// Brief  : Combinational spin index to one-hot flip mask with range flag.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module bitsieve_index_decoder #(
  parameter int N_SPINS = 1024,
  parameter int IDX_W   = 10
) (
  input  wire logic [IDX_W-1:0]   i_idx,
  input  wire logic               i_en,
  output logic      [N_SPINS-1:0] o_mask,
  output logic                    o_in_range
);
  // One bit wider than the index so N_SPINS == 2**IDX_W still fits.
  localparam logic [IDX_W:0] c_n_spins = (IDX_W+1)'(N_SPINS);

  assign o_in_range = ({1'b0, i_idx} < c_n_spins);

  // Out-of-range indices match no bit, so the mask stays all-zero for them.
  for (genvar i = 0; i < N_SPINS; i++) begin : g_bit
    assign o_mask[i] = i_en && (i_idx == IDX_W'(i));
  end
endmodule
`default_nettype wire

// File: rtl/bitsieve_flip_applier.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : bitsieve_flip_applier
// Brief  : Applies the winning BitSieve index as a single spin flip and
//          holds the flip announcement until the update engine acks it.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module bitsieve_flip_applier
  import bitsieve_pkg::*;
#(
  parameter int N_SPINS = DEFAULT_N_SPINS,
  parameter int IDX_W   = DEFAULT_IDX_W,
  parameter int CNT_W   = 32
) (
  input wire logic               clk,
  input wire logic               rst,
  bitsieve_flip_applier_if.slave bus
);
  state_e             r_state;
  logic [N_SPINS-1:0] r_spin;
  logic               r_flip_v;
  logic [IDX_W-1:0]   r_flip_idx;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_err;

  logic               w_ready;
  logic               w_accept;
  logic [N_SPINS-1:0] w_mask;
  logic               w_in_range;

  // A load in IDLE owns the cycle, so the index port is held off.
  assign w_ready  = (r_state == IDLE) && !bus.load_i;
  assign w_accept = bus.v_i && w_ready;

  bitsieve_index_decoder #(
    .N_SPINS (N_SPINS),
    .IDX_W   (IDX_W)
  ) u_dec (
    .i_idx      (bus.idx_i),
    .i_en       (w_accept),
    .o_mask     (w_mask),
    .o_in_range (w_in_range)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_spin     <= '0;
      r_flip_v   <= 1'b0;
      r_flip_idx <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.load_i) begin
            r_spin <= bus.spin_init_i;
          end else if (w_accept) begin
            if (w_in_range) begin
              r_spin     <= r_spin ^ w_mask;
              r_flip_idx <= bus.idx_i;
              r_flip_v   <= 1'b1;
              r_state    <= ANNOUNCE;
              if (r_cnt != '1) begin
                r_cnt <= r_cnt + 1'b1;
              end
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        ANNOUNCE: begin
          if (bus.flip_ack_i) begin
            r_flip_v <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ready_o    = w_ready;
  assign bus.spin_o     = r_spin;
  assign bus.flip_v_o   = r_flip_v;
  assign bus.flip_idx_o = r_flip_idx;
  assign bus.flip_cnt_o = r_cnt;
  assign bus.err_o      = r_err;
endmodule
`default_nettype wire

// File: tb/tb_bitsieve_flip_applier.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_bitsieve_flip_applier
// Brief  : Directed plus randomized bench against a behavioural spin model.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_bitsieve_flip_applier;
  localparam int N     = 1000;
  localparam int IW    = 10;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic clk;
  logic rst;

  bitsieve_flip_applier_if #(.N_SPINS(N), .IDX_W(IW), .CNT_W(CW)) bus ();

  bitsieve_flip_applier #(.N_SPINS(N), .IDX_W(IW), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Behavioural model: spin array, pending-flip flag, counter, sticky error.
  logic [N-1:0]  m_spin;
  bit            m_pend;
  int            m_fidx;
  int            m_cnt;
  bit            m_err;

  task automatic chk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_spin = '0; m_pend = 0; m_fidx = 0; m_cnt = 0; m_err = 0;
    end else if (!m_pend) begin
      if (bus.load_i) begin
        m_spin = bus.spin_init_i;
      end else if (bus.v_i) begin
        if (int'(bus.idx_i) < N) begin
          m_spin[bus.idx_i] = ~m_spin[bus.idx_i];
          m_pend = 1;
          m_fidx = int'(bus.idx_i);
          m_cnt  = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
        end else begin
          m_err = 1;
        end
      end
    end else if (bus.flip_ack_i) begin
      m_pend = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("spin",     1024'(bus.spin_o),     1024'(m_spin));
      chk("flip_v",   1024'(bus.flip_v_o),   1024'(m_pend));
      if (m_pend) chk("flip_idx", 1024'(bus.flip_idx_o), 1024'(m_fidx));
      chk("flip_cnt", 1024'(bus.flip_cnt_o), 1024'(m_cnt));
      chk("err",      1024'(bus.err_o),      1024'(m_err));
      chk("ready",    1024'(bus.ready_o),    1024'(!m_pend && !bus.load_i));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1023:0] e;

  initial begin
    rst = 1'b1;
    bus.idx_i = '0; bus.v_i = 0; bus.load_i = 0; bus.spin_init_i = '0; bus.flip_ack_i = 0;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_ready", 1024'(bus.ready_o),    1024'(1));
    chk("rst_cnt",   1024'(bus.flip_cnt_o), 1024'(0));
    chk("rst_spin",  1024'(bus.spin_o),     1024'(0));

    // Single flip of index 5.
    bus.v_i = 1; bus.idx_i = 10'd5;
    tick();
    e = '0; e[5] = 1'b1;
    chk("t1_spin",  1024'(bus.spin_o), e);
    chk("t1_fv",    1024'(bus.flip_v_o), 1024'(1));
    chk("t1_fidx",  1024'(bus.flip_idx_o), 1024'(5));
    chk("t1_ready", 1024'(bus.ready_o), 1024'(0));
    chk("t1_cnt",   1024'(bus.flip_cnt_o), 1024'(1));

    // Delayed ack: idx 7 must wait.
    bus.idx_i = 10'd7;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t2_hold_fidx", 1024'(bus.flip_idx_o), 1024'(5));
      chk("t2_hold_fv",   1024'(bus.flip_v_o), 1024'(1));
    end
    bus.flip_ack_i = 1;
    tick();
    chk("t2_ack_ready", 1024'(bus.ready_o), 1024'(1));
    chk("t2_ack_fv",    1024'(bus.flip_v_o), 1024'(0));
    tick();
    e[7] = 1'b1;
    chk("t2_spin", 1024'(bus.spin_o), e);
    chk("t2_cnt",  1024'(bus.flip_cnt_o), 1024'(2));

    // Index 0 twice with ack tied high: accept every 2 cycles.
    tick();
    bus.idx_i = 10'd0;
    tick();
    e[0] = 1'b1;
    chk("t3_spin_a", 1024'(bus.spin_o), e);
    tick();
    chk("t3_idle", 1024'(bus.ready_o), 1024'(1));
    tick();
    e[0] = 1'b0;
    chk("t3_spin_b", 1024'(bus.spin_o), e);
    chk("t3_cnt",    1024'(bus.flip_cnt_o), 1024'(4));
    bus.v_i = 0;
    tick();

    // Out-of-range index.
    bus.v_i = 1; bus.idx_i = 10'd1010;
    tick();
    bus.v_i = 0;
    chk("t4_err",   1024'(bus.err_o), 1024'(1));
    chk("t4_fv",    1024'(bus.flip_v_o), 1024'(0));
    chk("t4_ready", 1024'(bus.ready_o), 1024'(1));
    chk("t4_spin",  1024'(bus.spin_o), e);
    tick();
    chk("t4_sticky", 1024'(bus.err_o), 1024'(1));

    // Load beats a same-cycle request.
    bus.load_i = 1; bus.spin_init_i = '0; bus.spin_init_i[7:0] = 8'hA5;
    bus.v_i = 1; bus.idx_i = 10'd0;
    #1;
    chk("t5_ready_load", 1024'(bus.ready_o), 1024'(0));
    tick();
    chk("t5_spin_load", 1024'(bus.spin_o), 1024'(8'hA5));
    chk("t5_fv",        1024'(bus.flip_v_o), 1024'(0));
    bus.load_i = 0;
    tick();
    chk("t5_spin_flip", 1024'(bus.spin_o), 1024'(8'hA4));
    bus.v_i = 0;
    tick();

    // Reset while announcing.
    bus.flip_ack_i = 0; bus.v_i = 1; bus.idx_i = 10'd3;
    tick();
    bus.v_i = 0; rst = 1;
    tick();
    rst = 0;
    chk("t6_fv",    1024'(bus.flip_v_o), 1024'(0));
    chk("t6_spin",  1024'(bus.spin_o), 1024'(0));
    chk("t6_cnt",   1024'(bus.flip_cnt_o), 1024'(0));
    chk("t6_err",   1024'(bus.err_o), 1024'(0));
    chk("t6_ready", 1024'(bus.ready_o), 1024'(1));

    // Counter saturation: 20 flips with ack tied high.
    bus.flip_ack_i = 1; bus.v_i = 1; bus.idx_i = 10'd9;
    for (int k = 0; k < 40; k++) tick();
    bus.v_i = 0;
    tick();
    chk("sat_cnt", 1024'(bus.flip_cnt_o), 1024'(CMAX));

    // Randomized traffic, occasional reset.
    rst = 1;
    tick();
    rst = 0;
    for (int c = 0; c < 3000; c++) begin
      bus.v_i        = ($urandom_range(0, 2) != 0);
      bus.idx_i      = ($urandom_range(0, 9) == 0) ? IW'($urandom_range(N, 1023))
                                                   : IW'($urandom_range(0, N - 1));
      bus.load_i     = ($urandom_range(0, 15) == 0);
      if (bus.load_i) begin
        for (int k = 0; k < N; k++) bus.spin_init_i[k] = 1'($urandom);
      end
      bus.flip_ack_i = ($urandom_range(0, 1) == 1);
      rst            = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 0; bus.v_i = 0; bus.load_i = 0;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
